// File: rtl/bus_rr_sched.sv
// bus_rr_sched: 4-to-1 shared-bus scheduler and mux.
// Master 0 has absolute priority at grant time. Masters 1-3 are served round-robin,
// and each grant is limited to a quantum. A ready watchdog aborts hung transfers.
// Optional per-master transfer counters: define BUS_RR_SCHED_STATS_EN.
module bus_rr_sched #(
  parameter int unsigned QUANTUM  = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [3:0]   gnt,
  output logic         hrd0,
  input  logic [127:0] m_a,
  input  logic [127:0] m_d,
  input  logic [3:0]   m_we,
  input  logic [3:0]   m_rd,
  output logic [31:0]  m_spo,
  output logic [3:0]   m_ready,
  output logic [31:0]  a,
  output logic [31:0]  d,
  output logic         we,
  output logic         rd,
  input  logic [31:0]  spo,
  input  logic         ready,
  output logic         err,
  output logic [1:0]   err_id
`ifdef BUS_RR_SCHED_STATS_EN
  ,
  input  logic [1:0]   stat_sel,
  output logic [31:0]  stat_cnt
`endif
);

  localparam int unsigned QW = $clog2(QUANTUM + 1);
  localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [3:0]      r_gnt;
  logic [1:0]      r_id;
  logic [1:0]      r_rr;
  logic [QW-1:0]   r_qcnt;
  logic [WW-1:0]   r_wcnt;
  logic [1:0]      r_err_id;

  logic            w_pick_vld;
  logic [1:0]      w_pick_id;
  logic            w_gnt_any;
  logic            w_we;
  logic            w_rd;
  logic            w_xfer;
  logic            w_done;
  logic            w_wd_hit;
  logic            w_bound;
  logic            w_force;
  logic            w_release;

  // Round-robin successor among minor masters, wrapping 3 -> 1
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd3) ? 2'd1 : 2'(x + 2'd1);
  endfunction

  // Arbitration: master 0 first, else first minor at or after the rr pointer
  always_comb begin
    logic [1:0] c;
    w_pick_vld = 1'b0;
    w_pick_id  = 2'd0;
    c          = r_rr;
    if (req[0]) begin
      w_pick_vld = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!w_pick_vld && req[c]) begin
          w_pick_vld = 1'b1;
          w_pick_id  = c;
        end
        c = rr_next(c);
      end
    end
  end

  // Transfer tracking, watchdog hit and release decision for the current grant
  always_comb begin
    w_gnt_any = |r_gnt;
    w_we      = w_gnt_any & m_we[r_id];
    w_rd      = w_gnt_any & m_rd[r_id];
    w_xfer    = w_we | w_rd;
    w_done    = w_xfer & ready;
    w_wd_hit  = w_xfer & ~ready & (r_wcnt == WW'(TIMEOUT - 1));
    w_bound   = ~w_xfer | w_done | w_wd_hit;
    w_force   = (r_id != 2'd0) & (r_qcnt >= QW'(QUANTUM)) & (|(req & ~r_gnt)) & w_bound;
    w_release = ~req[r_id] | w_force;
  end

  // Bus mux driven from the registered grant; watchdog overrides strobes and data
  always_comb begin
    gnt     = r_gnt;
    a       = w_gnt_any ? m_a[{r_id, 5'd0} +: 32] : 32'd0;
    d       = w_gnt_any ? m_d[{r_id, 5'd0} +: 32] : 32'd0;
    we      = w_we & ~w_wd_hit;
    rd      = w_rd & ~w_wd_hit;
    m_ready = (w_done | w_wd_hit) ? r_gnt : 4'd0;
    m_spo   = w_wd_hit ? ERR_DATA : (w_gnt_any ? spo : 32'd0);
    err     = w_wd_hit;
    err_id  = w_wd_hit ? r_id : r_err_id;
    // rst gating keeps the herald low while reset is held with requests pending
    hrd0    = rst & (r_state == S_IDLE) & ~req[0] & (|req[3:1]);
  end

  // Scheduler FSM with grant, round-robin pointer, quantum and watchdog counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= 4'd0;
      r_id     <= 2'd0;
      r_rr     <= 2'd1;
      r_qcnt   <= '0;
      r_wcnt   <= '0;
      r_err_id <= 2'd0;
    end else begin
      if (w_wd_hit) r_err_id <= r_id;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'(4'd1 << w_pick_id);
            r_id    <= w_pick_id;
            r_qcnt  <= QW'(1);
            r_wcnt  <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'd0;
            r_qcnt  <= '0;
            r_wcnt  <= '0;
            if (r_id != 2'd0) r_rr <= rr_next(r_id);
          end else begin
            if (r_qcnt < QW'(QUANTUM)) r_qcnt <= QW'(r_qcnt + QW'(1));
            if (w_done || w_wd_hit)   r_wcnt <= '0;
            else if (w_xfer)          r_wcnt <= WW'(r_wcnt + WW'(1));
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef BUS_RR_SCHED_STATS_EN
  logic [31:0] r_stat [4];

  // Saturating count of completed transfers (aborts included) per master
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_ready[i] && (r_stat[i] != 32'hFFFF_FFFF)) r_stat[i] <= r_stat[i] + 32'd1;
      end
    end
  end

  assign stat_cnt = r_stat[stat_sel];
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched (QUANTUM=4, TIMEOUT=8) with a completion scoreboard.
module tb_bus_rr_sched;

  localparam logic [31:0] K   = 32'h5A5A_0000;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic         hrd0;
  logic [127:0] m_a;
  logic [127:0] m_d;
  logic [3:0]   m_we;
  logic [3:0]   m_rd;
  logic [31:0]  m_spo;
  logic [3:0]   m_ready;
  logic [31:0]  a;
  logic [31:0]  d;
  logic         we;
  logic         rd;
  logic [31:0]  spo;
  logic         ready;
  logic         err;
  logic [1:0]   err_id;
`ifdef BUS_RR_SCHED_STATS_EN
  logic [1:0]   stat_sel;
  logic [31:0]  stat_cnt;
`endif

  exp_t        sb_q[$];
  int unsigned st_exp[4];
  int          n_chk;
  int          n_fail;

  // Slave model: read data is a fixed function of the presented address
  assign spo = a ^ K;

  bus_rr_sched #(.QUANTUM(4), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .hrd0(hrd0),
    .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
    .m_spo(m_spo), .m_ready(m_ready),
    .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
    .err(err), .err_id(err_id)
`ifdef BUS_RR_SCHED_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end of test, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pop and compare an expected completion whenever any m_ready is seen
  task automatic sb_check();
    exp_t e;
    if (m_ready !== 4'd0) begin
      n_chk++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed m_ready %b expected none", m_ready);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_ready", 32'(m_ready), 32'(4'd1 << e.id));
        chk("sb_spo", m_spo, e.data);
      end
    end
  endtask

  // One bus cycle: drive at negedge, settle, check grant and scoreboard.
  // push: 0 none, 1 normal completion expected, 2 watchdog abort expected.
  task automatic cyc(input logic [3:0] r, input int m, input logic w, input logic rdx,
                     input logic [31:0] addr, input logic rdy, input logic [3:0] exp_gnt,
                     input int push);
    exp_t e;
    @(negedge clk);
    req   = r;
    m_we  = 4'd0;
    m_rd  = 4'd0;
    ready = rdy;
    if (m >= 0) begin
      m_we[m]          = w;
      m_rd[m]          = rdx;
      m_a[32*m +: 32]  = addr;
      m_d[32*m +: 32]  = ~addr;
    end
    if (push != 0) begin
      e.id   = m;
      e.data = (push == 2) ? ERR : (addr ^ K);
      sb_q.push_back(e);
      st_exp[m]++;
    end
    #1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    sb_check();
  endtask

  task automatic idle_cyc(input logic [3:0] r, input logic [3:0] exp_gnt);
    cyc(r, -1, 1'b0, 1'b0, 32'd0, 1'b0, exp_gnt, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; req = 4'd0; m_a = '0; m_d = '0; m_we = 4'd0; m_rd = 4'd0; ready = 1'b0;
    for (int i = 0; i < 4; i++) st_exp[i] = 0;
`ifdef BUS_RR_SCHED_STATS_EN
    stat_sel = 2'd0;
`endif
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_hrd0", 32'(hrd0), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_id", 32'(err_id), 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_strobes", 32'({we, rd}), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_spo", m_spo, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Round robin 1 then 2 with one idle cycle between grants
    idle_cyc(4'b0110, 4'b0000);
    cyc(4'b0110, 1, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 4'b0010, 1);
    chk("t1_a", a, 32'h0000_1000);
    chk("t1_rd", 32'(rd), 32'd1);
    cyc(4'b0110, 1, 1'b0, 1'b1, 32'h0000_1004, 1'b1, 4'b0010, 1);
    cyc(4'b0110, 1, 1'b0, 1'b1, 32'h0000_1008, 1'b1, 4'b0010, 1);
    idle_cyc(4'b0100, 4'b0010);
    idle_cyc(4'b0100, 4'b0000);
    chk("t1_hrd0_idle", 32'(hrd0), 32'd1);
    cyc(4'b0100, 2, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 4'b0100, 1);
    cyc(4'b0100, 2, 1'b0, 1'b1, 32'h0000_2004, 1'b1, 4'b0100, 1);
    cyc(4'b0100, 2, 1'b0, 1'b1, 32'h0000_2008, 1'b1, 4'b0100, 1);
    idle_cyc(4'b0000, 4'b0100);
    idle_cyc(4'b0000, 4'b0000);

    // Pointer now at 3: 1 and 3 requesting picks 3, then 1
    idle_cyc(4'b1010, 4'b0000);
    cyc(4'b1010, 3, 1'b1, 1'b0, 32'h0000_3000, 1'b1, 4'b1000, 1);
    chk("t1b_we", 32'(we), 32'd1);
    chk("t1b_d", d, ~32'h0000_3000);
    idle_cyc(4'b0010, 4'b1000);
    idle_cyc(4'b0010, 4'b0000);
    cyc(4'b0010, 1, 1'b0, 1'b1, 32'h0000_1100, 1'b1, 4'b0010, 1);
    idle_cyc(4'b0000, 4'b0010);
    idle_cyc(4'b0000, 4'b0000);

    // Master 0 and master 2 in the same idle cycle: master 0 wins
    idle_cyc(4'b0101, 4'b0000);
    chk("t2_hrd0_a", 32'(hrd0), 32'd0);
    cyc(4'b0101, 0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 4'b0001, 1);
    chk("t2_hrd0_b", 32'(hrd0), 32'd0);
    idle_cyc(4'b0100, 4'b0001);
    idle_cyc(4'b0100, 4'b0000);
    cyc(4'b0100, 2, 1'b1, 1'b0, 32'h0000_2100, 1'b1, 4'b0100, 1);
    idle_cyc(4'b0000, 4'b0100);
    idle_cyc(4'b0000, 4'b0000);

    // Quantum: master 1 streams while master 3 waits
    idle_cyc(4'b0010, 4'b0000);
    cyc(4'b1010, 1, 1'b0, 1'b1, 32'h0000_1200, 1'b1, 4'b0010, 1);
    cyc(4'b1010, 1, 1'b0, 1'b1, 32'h0000_1204, 1'b1, 4'b0010, 1);
    cyc(4'b1010, 1, 1'b0, 1'b1, 32'h0000_1208, 1'b1, 4'b0010, 1);
    cyc(4'b1010, 1, 1'b0, 1'b1, 32'h0000_120C, 1'b1, 4'b0010, 1);
    cyc(4'b1010, 1, 1'b0, 1'b1, 32'h0000_1210, 1'b1, 4'b0000, 0);
    cyc(4'b1010, 3, 1'b1, 1'b0, 32'h0000_3100, 1'b1, 4'b1000, 1);
    cyc(4'b0010, 1, 1'b0, 1'b1, 32'h0000_1214, 1'b1, 4'b1000, 0);
    cyc(4'b0010, 1, 1'b0, 1'b1, 32'h0000_1218, 1'b1, 4'b0000, 0);
    cyc(4'b0010, 1, 1'b0, 1'b1, 32'h0000_121C, 1'b1, 4'b0010, 1);
    idle_cyc(4'b0000, 4'b0010);
    idle_cyc(4'b0000, 4'b0000);

    // Watchdog: master 2 reads, slave never answers
    idle_cyc(4'b0100, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      cyc(4'b0100, 2, 1'b0, 1'b1, 32'h0000_2200, 1'b0, 4'b0100, 0);
      chk("t4_wait_err", 32'(err), 32'd0);
    end
    chk("t4_wait_rd", 32'(rd), 32'd1);
    cyc(4'b0100, 2, 1'b0, 1'b1, 32'h0000_2200, 1'b0, 4'b0100, 2);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_id", 32'(err_id), 32'd2);
    chk("t4_rd_forced", 32'(rd), 32'd0);
    idle_cyc(4'b0000, 4'b0100);
    chk("t4_err_pulse", 32'(err), 32'd0);
    chk("t4_err_id_hold", 32'(err_id), 32'd2);
    idle_cyc(4'b0000, 4'b0000);

    // Ready on the timeout cycle wins over the watchdog
    idle_cyc(4'b1000, 4'b0000);
    for (int i = 0; i < 7; i++)
      cyc(4'b1000, 3, 1'b0, 1'b1, 32'h0000_3200, 1'b0, 4'b1000, 0);
    cyc(4'b1000, 3, 1'b0, 1'b1, 32'h0000_3200, 1'b1, 4'b1000, 1);
    chk("t4b_no_err", 32'(err), 32'd0);
    chk("t4b_err_id", 32'(err_id), 32'd2);
    idle_cyc(4'b0000, 4'b1000);
    idle_cyc(4'b0000, 4'b0000);

    // Asynchronous reset during a master 3 write
    idle_cyc(4'b1000, 4'b0000);
    cyc(4'b1000, 3, 1'b1, 1'b0, 32'h0000_3300, 1'b0, 4'b1000, 0);
    chk("t5_we_before", 32'(we), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_we", 32'(we), 32'd0);
    chk("t5_hrd0", 32'(hrd0), 32'd0);
    chk("t5_err_id", 32'(err_id), 32'd0);
    for (int i = 0; i < 4; i++) st_exp[i] = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_gnt_rel", 32'(gnt), 32'd0);
    idle_cyc(4'b1000, 4'b1000);
    idle_cyc(4'b0000, 4'b1000);
    idle_cyc(4'b0000, 4'b0000);

    // Statistics traffic: 5 by master 1, 2 by master 0
    idle_cyc(4'b0010, 4'b0000);
    for (int i = 0; i < 5; i++)
      cyc(4'b0010, 1, 1'b0, 1'b1, 32'h0000_1300 + 32'(4 * i), 1'b1, 4'b0010, 1);
    idle_cyc(4'b0001, 4'b0010);
    idle_cyc(4'b0001, 4'b0000);
    cyc(4'b0001, 0, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 4'b0001, 1);
    cyc(4'b0001, 0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 4'b0001, 1);
    idle_cyc(4'b0000, 4'b0001);
    idle_cyc(4'b0000, 4'b0000);
`ifdef BUS_RR_SCHED_STATS_EN
    stat_sel = 2'd1;
    #1 chk("t6_stat1", stat_cnt, 32'(st_exp[1]));
    stat_sel = 2'd0;
    #1 chk("t6_stat0", stat_cnt, 32'(st_exp[0]));
    stat_sel = 2'd3;
    #1 chk("t6_stat3", stat_cnt, 32'(st_exp[3]));
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
